// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, 2-FF row sync, ghost rejection and debounce.
// Define KEYPAD_REPEAT_EN to add auto-repeat pulses while a key is held.
module keypad_scan #(
    parameter int unsigned SCAN_DIV       = 16,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_SCANS   = 64
) (
    input  logic       clkin,
    input  logic       greset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DivW = $clog2(SCAN_DIV);
    localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {StIdle, StPress, StHeld, StRelease} state_e;

    logic [3:0]      row_meta, row_sync;
    logic [DivW-1:0] div_q;
    logic [1:0]      col_idx_q;
    logic [1:0]      hits_q;   // pressed bits seen so far this scan, saturated at 2
    logic [3:0]      code_q;

    state_e          state_q;
    logic [3:0]      cand_q;
    logic [CntW-1:0] cnt_q;
    logic [3:0]      key_q;
    logic            key_valid_q, key_held_q;

    logic [3:0]      pressed;
    logic [2:0]      col_sum, tot_sum;
    logic [1:0]      col_row, tot_hits;
    logic [3:0]      scan_code;
    logic [CntW-1:0] cnt_inc;
    logic            last_dwell, scan_end, scan_single, accept;
    logic            rep_fire;

    assign col       = ~(4'b0001 << col_idx_q);
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

    assign pressed    = ~row_sync;
    assign last_dwell = (div_q == DivW'(SCAN_DIV - 1));
    assign scan_end   = last_dwell && (col_idx_q == 2'd3);

    assign col_sum = 3'(pressed[0]) + 3'(pressed[1]) + 3'(pressed[2]) + 3'(pressed[3]);

    always_comb begin
        col_row = 2'd0;
        if (pressed[1]) col_row = 2'd1;
        if (pressed[2]) col_row = 2'd2;
        if (pressed[3]) col_row = 2'd3;
    end

    // Scan totals include the column being sampled right now.
    assign tot_sum     = {1'b0, hits_q} + ((col_sum > 3'd1) ? 3'd2 : col_sum);
    assign tot_hits    = (tot_sum >= 3'd2) ? 2'd2 : tot_sum[1:0];
    assign scan_code   = (col_sum == 3'd1) ? {col_row, col_idx_q} : code_q;
    assign scan_single = (tot_hits == 2'd1);

    assign cnt_inc = (cnt_q == CntW'(DEBOUNCE_SCANS)) ? cnt_q : cnt_q + CntW'(1);

    assign accept = scan_end && scan_single &&
                    (((state_q == StIdle) && (DEBOUNCE_SCANS == 1)) ||
                     ((state_q == StPress) && (scan_code == cand_q) &&
                      (cnt_inc == CntW'(DEBOUNCE_SCANS))));

    always_ff @(posedge clkin) begin
        if (greset) begin
            row_meta  <= 4'hF;
            row_sync  <= 4'hF;
            div_q     <= '0;
            col_idx_q <= 2'd0;
            hits_q    <= 2'd0;
            code_q    <= 4'h0;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
            if (last_dwell) begin
                div_q     <= '0;
                col_idx_q <= col_idx_q + 2'd1;
                if (col_idx_q == 2'd3) begin
                    hits_q <= 2'd0;
                    code_q <= 4'h0;
                end else begin
                    hits_q <= tot_hits;
                    code_q <= scan_code;
                end
            end else begin
                div_q <= div_q + DivW'(1);
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RepW = $clog2(REPEAT_SCANS + 1);

    logic [RepW-1:0] rep_q;
    logic            stay_held, rehold;

    assign stay_held = scan_end && scan_single && (state_q == StHeld);
    assign rehold    = scan_end && scan_single && (state_q == StRelease);
    assign rep_fire  = stay_held && (rep_q == RepW'(REPEAT_SCANS - 1));

    always_ff @(posedge clkin) begin
        if (greset || accept || rehold) begin
            rep_q <= '0;
        end else if (stay_held) begin
            rep_q <= rep_fire ? '0 : rep_q + RepW'(1);
        end
    end
`else
    logic unused_repeat;
    assign unused_repeat = ^REPEAT_SCANS;
    assign rep_fire      = 1'b0;
`endif

    always_ff @(posedge clkin) begin
        if (greset) begin
            state_q     <= StIdle;
            cand_q      <= 4'h0;
            cnt_q       <= '0;
            key_q       <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= accept | rep_fire;
            if (scan_end) begin
                unique case (state_q)
                    StIdle: begin
                        if (scan_single) begin
                            cand_q  <= scan_code;
                            cnt_q   <= CntW'(1);
                            state_q <= accept ? StHeld : StPress;
                        end
                    end
                    StPress: begin
                        if (!scan_single) begin
                            state_q <= StIdle;
                            cnt_q   <= '0;
                        end else if (scan_code != cand_q) begin
                            cand_q <= scan_code;
                            cnt_q  <= CntW'(1);
                        end else begin
                            cnt_q <= cnt_inc;
                            if (accept) state_q <= StHeld;
                        end
                    end
                    StHeld: begin
                        // Any single key keeps the hold; a new key waits for full release.
                        if (!scan_single) begin
                            cnt_q <= CntW'(1);
                            if (DEBOUNCE_SCANS == 1) begin
                                state_q    <= StIdle;
                                key_held_q <= 1'b0;
                            end else begin
                                state_q <= StRelease;
                            end
                        end
                    end
                    StRelease: begin
                        // Release bounce: return to the hold silently, no new report.
                        if (scan_single) begin
                            state_q <= StHeld;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                            if (cnt_inc == CntW'(DEBOUNCE_SCANS)) begin
                                state_q    <= StIdle;
                                key_held_q <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
                if (accept) begin
                    key_q      <= scan_code;
                    key_held_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: keypad matrix model, scan-level reference model, key_valid scoreboard.
module tb_keypad_scan;

    localparam int SD = 4;
    localparam int DB = 3;
    localparam int RS = 5;

    logic        clk = 1'b0;
    logic        greset = 1'b1;
    logic [3:0]  row, col, key;
    logic        key_valid, key_held;
    logic [15:0] pressed = 16'h0;

    always #5 clk = ~clk;

    keypad_scan #(
        .SCAN_DIV      (SD),
        .DEBOUNCE_SCANS(DB),
        .REPEAT_SCANS  (RS)
    ) dut (
        .clkin    (clk),
        .greset   (greset),
        .row      (row),
        .col      (col),
        .key      (key),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    // Physical keypad: a pressed switch shorts its row to its column.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] sb_q[$];

    bit         m_held;
    logic [3:0] m_key;
    int         run, last_res, rep;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every key_valid pulse must match the oldest expected report.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0 || prev_valid) begin
                n_fail++;
                $display("FAIL key_valid: got unexpected pulse (key %0h) expected none at %0t",
                         key, $time);
            end else begin
                logic [3:0] exp_key;
                exp_key = sb_q.pop_front();
                check("pulse key", 16'(key), 16'(exp_key));
                check("pulse held", 16'(key_held), 16'd1);
            end
        end
        prev_valid = key_valid;
    end

    // Scan-level reference: a result is SINGLE(code) iff exactly one switch is down.
    task automatic model_scan(input logic [15:0] p, output bit pulse);
        int res, prev;
        res = -1;
        if ($countones(p) == 1)
            for (int i = 0; i < 16; i++) if (p[i]) res = i;
        prev     = last_res;
        run      = (res == last_res) ? run + 1 : 1;
        last_res = res;
        pulse    = 1'b0;
        if (!m_held) begin
            if (res >= 0 && run == DB) begin
                m_held = 1'b1;
                m_key  = res[3:0];
                pulse  = 1'b1;
                rep    = 0;
            end
        end else if (res < 0) begin
            if (run == DB) m_held = 1'b0;
        end else if (prev < 0) begin
            rep = 0;
        end
`ifdef KEYPAD_REPEAT_EN
        else begin
            rep++;
            if (rep == RS) begin
                rep   = 0;
                pulse = 1'b1;
            end
        end
`endif
    endtask

    task automatic model_reset();
        m_held   = 1'b0;
        m_key    = 4'h0;
        run      = 0;
        last_res = -1;
        rep      = 0;
        sb_q.delete();
    endtask

    // Called at a scan boundary (just after a negedge); leaves at the next boundary.
    task automatic run_scan(input logic [15:0] p);
        bit pulse;
        pressed = p;
        model_scan(p, pulse);
        if (pulse) sb_q.push_back(m_key);
        for (int i = 0; i < 4 * SD; i++) begin
            check("col", 16'(col), 16'(4'hF ^ (4'h1 << (i / SD))));
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        if (pulse) check("pulse seen", 16'(sb_q.size()), 16'd0);
        check("key_held", 16'(key_held), 16'(m_held));
        check("key", 16'(key), 16'(m_key));
    endtask

    task automatic scans(input logic [15:0] p, input int n);
        for (int i = 0; i < n; i++) run_scan(p);
    endtask

    task automatic do_reset();
        @(negedge clk);
        greset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        greset = 1'b0;
        model_reset();
        #1;
        check("reset col", 16'(col), 16'hE);
        check("reset key", 16'(key), 16'h0);
        check("reset key_valid", 16'(key_valid), 16'h0);
        check("reset key_held", 16'(key_held), 16'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish by 500000");
        $fatal(1);
    end

    initial begin
        logic [15:0] p;
        model_reset();
        do_reset();

        scans(16'h0000, 4);                       // idle column walk
        scans(16'h0200, 4);                       // r2,c1 -> 9
        scans(16'h0000, 4);
        scans(16'h0008, 2);                       // bounce on r0,c3
        scans(16'h0000, 1);
        scans(16'h0008, 3);
        scans(16'h0000, 3);
        scans(16'h0050, 4);                       // ghost r1,c0 + r1,c2
        scans(16'h0010, 3);                       // c2 released -> 4
        scans(16'h0000, 3);
        scans(16'h0200, 3);                       // hold 9, add F, drop 9
        scans(16'h8200, 1);
        scans(16'h8000, 4);
        scans(16'h0000, 4);
        scans(16'h0200, 3);
        scans(16'h0000, 3);

        for (int seg = 0; seg < 40; seg++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 4) p = 16'h0;
            else if (r < 8) p = 16'h1 << $urandom_range(0, 15);
            else p = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            scans(p, $urandom_range(1, 2 * DB + 1));
        end
        scans(16'h0000, DB);

        // Reset in the middle of column 2 while a key is held.
        scans(16'h0200, 4);
        pressed = 16'h0200;
        repeat (2 * SD + 1) @(posedge clk);
        @(negedge clk);
        greset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        greset = 1'b0;
        model_reset();
        #1;
        check("mid reset col", 16'(col), 16'hE);
        check("mid reset key_held", 16'(key_held), 16'h0);
        check("mid reset key", 16'(key), 16'h0);
        scans(16'h0200, 4);
        scans(16'h0000, DB);

        check("scoreboard drained", 16'(sb_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
